// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared types and constants for the pushbutton conditioner
package key_cond_pkg;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    localparam int DEB_SIM   = 4;
    localparam int DEB_BOARD = 16;

    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one pushbutton channel - sync, debounce, edge strobes, optional auto-repeat
//   clk, resetn (async active-low) | key: raw active-low button
//   key_down: debounced level | key_press/key_release: one-cycle edge strobes
//   key_repeat: auto-repeat strobe, only with KEY_CONDITIONER_AUTO_REPEAT_EN, else 0
module key_debounce_ch
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEB_BOARD,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic key,
    output logic key_down,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);
    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, flip;
    logic [DW-1:0] cnt;
    // stable raw level is ~key_down, so a differing sample means s2 == key_down
    assign flip = (s2 == key_down) && (cnt == DMAX);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1          <= 1'b1;
            s2          <= 1'b1;
            cnt         <= '0;
            key_down    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            s1          <= key;
            s2          <= s1;
            cnt         <= (s2 != key_down || flip) ? '0 : cnt + 1'b1;
            key_down    <= key_down ^ flip;
            key_press   <= flip & ~key_down;
            key_release <= flip & key_down;
        end
    end
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_w(RMAX);
    localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_PERIOD - 1);
    rpt_state_t state, state_n;
    logic [RW-1:0] rcnt, rcnt_n;
    logic hit;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_n;
            rcnt  <= rcnt_n;
        end
    end
    // gating with key_down lets a release suppress a coincident repeat
    always_comb begin
        state_n    = state;
        rcnt_n     = rcnt + 1'b1;
        hit        = (state == DELAY && rcnt == RD_MAX) || (state == REPEAT && rcnt == RP_MAX);
        key_repeat = key_down & hit;
        if (!key_down) begin
            state_n = IDLE;
            rcnt_n  = '0;
        end else if (state == IDLE) begin
            state_n = key_press ? DELAY : IDLE;
            rcnt_n  = '0;
        end else if (hit) begin
            state_n = REPEAT;
            rcnt_n  = '0;
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = (REPEAT_DELAY + REPEAT_PERIOD) > 0;
    assign key_repeat = 1'b0;
`endif
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: synchronise, debounce and edge-detect the active-low pushbuttons
//   CLOCK_50, resetn (async active-low) | KEY[N_KEYS]: raw buttons, 0 = pressed
//   key_down: debounced level | key_press/key_release: one-cycle strobes
//   key_repeat: auto-repeat strobes when KEY_CONDITIONER_AUTO_REPEAT_EN is defined, else 0
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEB_BOARD,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_down,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);
    genvar i;
    generate
        for (i = 0; i < N_KEYS; i++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_ch (
                .clk        (CLOCK_50),
                .resetn     (resetn),
                .key        (KEY[i]),
                .key_down   (key_down[i]),
                .key_press  (key_press[i]),
                .key_release(key_release[i]),
                .key_repeat (key_repeat[i])
            );
        end
    endgenerate
endmodule
